// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC control path: opcodes, FSM states, ALU
// operation codes, status flag positions and an ALU-op helper.
package sisc_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ALU_R = 4'b0001;
    localparam logic [3:0] OP_ALU_I = 4'b0010;
    localparam logic [3:0] OP_LOD   = 4'b0011;
    localparam logic [3:0] OP_STR   = 4'b0100;
    localparam logic [3:0] OP_BRA   = 4'b0101;
    localparam logic [3:0] OP_BRR   = 4'b0110;
    localparam logic [3:0] OP_BNE   = 4'b0111;
    localparam logic [3:0] OP_HLT   = 4'b1111;

    typedef enum logic [2:0] {
        ST_START0    = 3'd0,
        ST_START1    = 3'd1,
        ST_FETCH     = 3'd2,
        ST_DECODE    = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_MEM       = 3'd5,
        ST_WRITEBACK = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

    localparam logic [1:0] ALU_RR   = 2'b00;
    localparam logic [1:0] ALU_RI   = 2'b01;
    localparam logic [1:0] ALU_ADDR = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    // ALU operation an instruction uses while it owns the datapath.
    function automatic logic [1:0] alu_op_for(input logic [3:0] op);
        logic [1:0] res;
        case (op)
            OP_ALU_R:       res = ALU_RR;
            OP_ALU_I:       res = ALU_RI;
            OP_LOD, OP_STR: res = ALU_ADDR;
            OP_NOP:         res = ALU_PASS;
            default:        res = ALU_PASS;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sisc_br_cond.sv
// Combinational branch evaluator: decides taken/not-taken from the
// opcode, the condition mask and the latched status flags.
module sisc_br_cond
    import sisc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       taken
);

    logic cond_s;

    // A zero mask on BRA/BRR means "always"; BNE inverts the flag match.
    always_comb begin
        cond_s = (mm[FLAG_C] & stat[FLAG_C]) | (mm[FLAG_N] & stat[FLAG_N]) |
                 (mm[FLAG_V] & stat[FLAG_V]) | (mm[FLAG_Z] & stat[FLAG_Z]);
        case (opcode)
            OP_BRA, OP_BRR: taken = cond_s | (mm == 4'b0000);
            OP_BNE:         taken = ~cond_s;
            default:        taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/sisc_ctrl.sv
// Multicycle SISC control FSM: sequences fetch/decode/execute/mem/writeback
// and decodes the Moore-style datapath strobes from the current state.
module sisc_ctrl
    import sisc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_f,
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       ir_load,
    output logic       pc_write,
    output logic       pc_sel,
    output logic       br_sel,
    output logic       rb_sel,
    output logic [1:0] alu_op,
    output logic       stat_en,
    output logic       dm_we,
    output logic       wb_sel,
    output logic       rf_we,
    output logic       halted,
    output logic [2:0] state
);

    state_t state_r;
    state_t state_nx_s;
    logic   taken_s;

    sisc_br_cond u_br_cond (
        .opcode (opcode),
        .mm     (mm),
        .stat   (stat),
        .taken  (taken_s)
    );

    assign state = state_r;

    // State register; reset clears it immediately so strobes drop at once.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_r <= ST_START0;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_START0:    state_nx_s = ST_START1;
            ST_START1:    state_nx_s = ST_FETCH;
            ST_FETCH:     state_nx_s = ST_DECODE;
            ST_DECODE: begin
                if (opcode == OP_HLT) begin
                    state_nx_s = ST_HALT;
                end else begin
                    state_nx_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                case (opcode)
                    OP_LOD, OP_STR:     state_nx_s = ST_MEM;
                    OP_ALU_R, OP_ALU_I: state_nx_s = ST_WRITEBACK;
                    default:            state_nx_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (opcode == OP_LOD) begin
                    state_nx_s = ST_WRITEBACK;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_WRITEBACK: state_nx_s = ST_FETCH;
            ST_HALT:      state_nx_s = ST_HALT;
            default:      state_nx_s = ST_START0;
        endcase
    end

    // Output decode; everything idles low unless the state claims it.
    always_comb begin
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        rb_sel   = 1'b0;
        alu_op   = ALU_RR;
        stat_en  = 1'b0;
        dm_we    = 1'b0;
        wb_sel   = 1'b0;
        rf_we    = 1'b0;
        halted   = 1'b0;
        case (state_r)
            ST_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                pc_sel   = 1'b0;
            end
            ST_DECODE: begin
                rb_sel = (opcode == OP_STR);
            end
            ST_EXECUTE: begin
                alu_op = alu_op_for(opcode);
                case (opcode)
                    OP_ALU_R, OP_ALU_I: stat_en = 1'b1;
                    OP_STR:             rb_sel  = 1'b1;
                    OP_BRA, OP_BRR, OP_BNE: begin
                        pc_write = taken_s;
                        pc_sel   = taken_s;
                        br_sel   = taken_s & (opcode == OP_BRA);
                    end
                    default:            stat_en = 1'b0;
                endcase
            end
            ST_MEM: begin
                alu_op = ALU_ADDR;
                if (opcode == OP_STR) begin
                    rb_sel = 1'b1;
                    dm_we  = 1'b1;
                end else begin
                    dm_we  = 1'b0;
                end
            end
            ST_WRITEBACK: begin
                rf_we  = 1'b1;
                alu_op = alu_op_for(opcode);
                wb_sel = (opcode == OP_LOD);
            end
            ST_HALT: begin
                halted = 1'b1;
                alu_op = ALU_PASS;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Self-checking bench for sisc_ctrl: per-cycle comparison against an
// instruction-level model, directed test-plan cases and randomized programs.
module tb_sisc_ctrl;

    logic       clk = 1'b0;
    logic       rst_f = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic [3:0] mm = 4'd0;
    logic [3:0] stat = 4'd0;
    logic       ir_load, pc_write, pc_sel, br_sel, rb_sel;
    logic [1:0] alu_op;
    logic       stat_en, dm_we, wb_sel, rf_we, halted;
    logic [2:0] state;

    sisc_ctrl dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .ir_load  (ir_load),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .rb_sel   (rb_sel),
        .alu_op   (alu_op),
        .stat_en  (stat_en),
        .dm_we    (dm_we),
        .wb_sel   (wb_sel),
        .rf_we    (rf_we),
        .halted   (halted),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Packed view: [14:12] state, 11 halted, 10 ir_load, 9 pc_write,
    // 8 pc_sel, 7 br_sel, 6 rb_sel, [5:4] alu_op, 3 stat_en, 2 dm_we,
    // 1 wb_sel, 0 rf_we.
    logic [14:0] dut_vec;
    assign dut_vec = {state, halted, ir_load, pc_write, pc_sel, br_sel, rb_sel,
                      alu_op, stat_en, dm_we, wb_sel, rf_we};

    int          checks = 0;
    int          errors = 0;
    int          m_state = 0;
    logic [3:0]  m_op = 4'd0;
    logic [3:0]  m_mm = 4'd0;
    logic [3:0]  m_stat = 4'd0;
    int          m_q[$];
    logic [11:0] dir_q[$];
    logic [14:0] trace[$];
    int          alur_exp[7] = '{0, 1, 2, 3, 4, 6, 2};
    int          lod_exp[6]  = '{2, 3, 4, 5, 6, 2};

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outputs from instruction class and phase.
    function automatic logic [14:0] model_out(input int s, input logic [3:0] op,
                                              input logic [3:0] mmv, input logic [3:0] stv);
        logic       h, irl, pcw, pcs, brs, rbs, se, dw, ws, rw, tk, is_br;
        logic [1:0] alu;
        logic [2:0] s3;
        s3 = s[2:0];
        {h, irl, pcw, pcs, brs, rbs, se, dw, ws, rw} = 10'd0;
        alu = 2'd0;
        is_br = (op == 4'd5) || (op == 4'd6) || (op == 4'd7);
        if (op == 4'd7) tk = ((mmv & stv) == 4'd0);
        else tk = is_br && (((mmv & stv) != 4'd0) || (mmv == 4'd0));
        case (s)
            2: begin irl = 1'b1; pcw = 1'b1; end
            3: rbs = (op == 4'd4);
            4: begin
                if (op == 4'd1) begin alu = 2'd0; se = 1'b1; end
                else if (op == 4'd2) begin alu = 2'd1; se = 1'b1; end
                else if (op == 4'd3 || op == 4'd4) begin alu = 2'd2; rbs = (op == 4'd4); end
                else if (is_br) begin pcw = tk; pcs = tk; brs = tk && (op == 4'd5); end
                else alu = 2'd3;
            end
            5: begin alu = 2'd2; rbs = (op == 4'd4); dw = (op == 4'd4); end
            6: begin
                rw = 1'b1;
                ws = (op == 4'd3);
                alu = (op == 4'd1) ? 2'd0 : (op == 4'd2) ? 2'd1 : 2'd2;
            end
            7: begin h = 1'b1; alu = 2'd3; end
            default: h = 1'b0;
        endcase
        return {s3, h, irl, pcw, pcs, brs, rbs, alu, se, dw, ws, rw};
    endfunction

    // IR load: next directed instruction, else a random one (never HLT).
    task automatic load_instr();
        logic [11:0] w;
        if (dir_q.size() > 0) begin
            w = dir_q.pop_front();
        end else begin
            w[11:8] = 4'($urandom_range(0, 14));
            w[7:4]  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            w[3:0]  = 4'($urandom_range(0, 15));
        end
        m_op = w[11:8]; m_mm = w[7:4]; m_stat = w[3:0];
        opcode = m_op; mm = m_mm; stat = m_stat;
        m_q.delete();
        case (m_op)
            4'd1, 4'd2: begin m_q.push_back(4); m_q.push_back(6); m_q.push_back(2); end
            4'd3: begin m_q.push_back(4); m_q.push_back(5); m_q.push_back(6); m_q.push_back(2); end
            4'd4: begin m_q.push_back(4); m_q.push_back(5); m_q.push_back(2); end
            4'd15: m_q.push_back(7);
            default: begin m_q.push_back(4); m_q.push_back(2); end
        endcase
    endtask

    task automatic advance();
        if (rst_f) begin
            m_state = 0;
            m_q.delete();
            m_q.push_back(1);
            m_q.push_back(2);
        end else begin
            if (m_q.size() > 0) m_state = m_q.pop_front();
            if (m_state == 2) begin
                m_q.delete();
                m_q.push_back(3);
            end else if (m_state == 3) begin
                load_instr();
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        advance();
    endtask

    function automatic int count_bit(input int b, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(trace[i][b]);
        return n;
    endfunction

    // Single compare process: DUT against the model every cycle.
    always @(negedge clk) begin : cmp_blk
        logic [14:0] mv;
        logic [14:0] mk;
        mv = model_out(m_state, m_op, m_mm, m_stat);
        mk = (m_state == 4 && (m_op == 4'd5 || m_op == 4'd6 || m_op == 4'd7)) ? 15'h7fcf : 15'h7fff;
        check($sformatf("cycle st%0d op%0h", m_state, m_op), dut_vec & mk, mv & mk);
        if (trace.size() < 64) trace.push_back(dut_vec);
    end

    initial begin
        int cnt;
        m_q.push_back(1);
        m_q.push_back(2);
        repeat (3) @(posedge clk);
        #1 rst_f = 1'b0;
        trace.delete();
        dir_q.push_back(12'h100);
        dir_q.push_back(12'h300);
        dir_q.push_back(12'h400);
        dir_q.push_back(12'h644);
        dir_q.push_back(12'h640);
        dir_q.push_back(12'h711);
        dir_q.push_back(12'h500);
        repeat (28) step();

        check("reset_vec", trace[0], 15'd0);
        for (int i = 0; i < 7; i++)
            check($sformatf("alur_state%0d", i), 15'(trace[i][14:12]), 15'(alur_exp[i]));
        check("alur_stat_en_cnt", 15'(count_bit(3, 0, 6)), 15'd1);
        check("alur_stat_en_c4", 15'(trace[4][3]), 15'd1);
        check("alur_rf_we_cnt", 15'(count_bit(0, 0, 6)), 15'd1);
        check("alur_wb", 15'(trace[5][5:0]), 15'h01);
        for (int i = 0; i < 6; i++)
            check($sformatf("lod_state%0d", i), 15'(trace[6 + i][14:12]), 15'(lod_exp[i]));
        check("lod_alu_ex", 15'(trace[8][5:4]), 15'd2);
        check("lod_alu_mem", 15'(trace[9][5:4]), 15'd2);
        check("lod_wb", 15'(trace[10][1:0]), 15'd3);
        check("lod_dm_we", 15'(count_bit(2, 6, 11)), 15'd0);
        check("str_rb_sel", 15'(count_bit(6, 12, 14)), 15'd3);
        check("str_dm_we_cnt", 15'(count_bit(2, 11, 15)), 15'd1);
        check("str_dm_we_mem", 15'(trace[14][2]), 15'd1);
        check("str_rf_we", 15'(count_bit(0, 11, 15)), 15'd0);
        check("brr_taken", 15'(trace[17][9:7]), 15'b110);
        check("brr_not_ex", 15'(trace[20][9]), 15'd0);
        check("brr_not_pcw", 15'(count_bit(9, 18, 21)), 15'd2);
        check("bne_not", 15'(trace[23][9]), 15'd0);
        check("bra_taken", 15'(trace[26][9:7]), 15'b111);

        repeat (1500) step();

        // Asynchronous reset in the middle of an ALU_I writeback.
        dir_q.push_back(12'h2a5);
        cnt = 0;
        while (!(m_state == 6 && m_op == 4'd2) && cnt < 30) begin
            step();
            cnt++;
        end
        check("alui_wb_rf_we", 15'(rf_we), 15'd1);
        #2 rst_f = 1'b1;
        #1;
        check("async_rf_we", 15'(rf_we), 15'd0);
        check("async_state", 15'(state), 15'd0);
        check("async_halted", 15'(halted), 15'd0);
        advance();
        repeat (2) step();
        rst_f = 1'b0;
        repeat (40) step();

        // Halt and stay halted until reset.
        dir_q.push_back(12'hf00);
        cnt = 0;
        while (m_state != 7 && cnt < 30) begin
            step();
            cnt++;
        end
        repeat (12) step();
        check("halt_held", 15'(halted), 15'd1);
        check("halt_state", 15'(state), 15'd7);
        rst_f = 1'b1;
        advance();
        #1;
        check("halt_reset_state", 15'(state), 15'd0);
        check("halt_reset_halted", 15'(halted), 15'd0);
        step();
        rst_f = 1'b0;
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
